// File: rtl/pc_hazard_ctrl_pkg.sv
// Shared encodings for the PC / pipeline hazard controller: FSM states,
// PC source selects, the stall enable level and the default trap vector.
package pc_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BJ  = 1'b1;
  localparam logic STALL_EN   = 1'b1;

  localparam logic [31:0] TRAP_VECTOR_DEF = 32'h0000_0100;

endpackage

// File: rtl/pc_hazard_ctrl_sat_counter.sv
// Saturating event counter: clear wins over inc, holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_hazard_ctrl.sv
// Drives PC source/stall and IF/ID, ID/EX control from load-use, branch and trap events.
// Outputs are Mealy (same cycle); a small FSM sequences the post-redirect flush window.
module pc_hazard_ctrl
  import pc_hazard_ctrl_pkg::*;
#(
  parameter int                    PC_WIDTH     = 32,
  parameter int                    REG_ADDR_W   = 5,
  parameter int                    FLUSH_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0]   TRAP_VECTOR  = PC_WIDTH'(TRAP_VECTOR_DEF),
  parameter int                    CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_bj_taken,
  input  logic [PC_WIDTH-1:0]   ex_target_pc,
  input  logic                  trap_req,
  output logic                  pc_src,
  output logic [PC_WIDTH-1:0]   target_pc,
  output logic                  pc_stall,
  output logic                  if_id_hold,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t     r_state;
  logic [2:0] r_fcnt;

  logic w_lu;
  logic w_redirect;
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_lu = ex_is_load && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  assign w_redirect = trap_req || ex_bj_taken;

  // A redirect suppresses the stall: the PC gives stall priority over pc_src.
  always_comb begin
    pc_src       = PC_SRC_SEQ;
    target_pc    = '0;
    pc_stall     = 1'b0;
    if_id_hold   = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    busy         = 1'b0;
    if (!rst) begin
      if (trap_req) begin
        pc_src       = PC_SRC_BJ;
        target_pc    = TRAP_VECTOR;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (ex_bj_taken) begin
        pc_src       = PC_SRC_BJ;
        target_pc    = ex_target_pc;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if ((r_state == ST_RUN) && w_lu) begin
        pc_stall     = STALL_EN;
        if_id_hold   = 1'b1;
        id_ex_bubble = 1'b1;
      end
      if (r_state == ST_FLUSH) begin
        if_id_flush = 1'b1;
      end
      busy = (r_state != ST_RUN);
    end
  end

  // r_fcnt counts the FLUSH cycles still to run, so the redirect cycle plus
  // the FLUSH state together flush IF/ID for FLUSH_CYCLES cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_fcnt  <= 3'd0;
    end else if (w_redirect) begin
      if (FLUSH_CYCLES == 1) begin
        r_state <= ST_RUN;
        r_fcnt  <= 3'd0;
      end else begin
        r_state <= ST_FLUSH;
        r_fcnt  <= FLUSH_LOAD;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_lu) r_state <= ST_LU_STALL;
        end
        ST_LU_STALL: begin
          r_state <= ST_RUN;
        end
        ST_FLUSH: begin
          r_fcnt <= r_fcnt - 3'd1;
          if (r_fcnt <= 3'd1) r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_RUN;
          r_fcnt  <= 3'd0;
        end
      endcase
    end
  end

  assign w_stall_inc = (r_state == ST_RUN) && w_lu && !w_redirect;
  assign w_flush_inc = w_redirect;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .i_inc   (w_stall_inc),
    .i_clear (rst),
    .o_cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .i_inc   (w_flush_inc),
    .i_clear (rst),
    .o_cnt   (flush_cnt)
  );

endmodule
